// File: rtl/fec_rx_deframer.sv
// fec_rx_deframer: serial FEC frame collector feeding a block decoder.
// Captures data, row parity and column parity bits, then hands off.
module fec_rx_deframer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_bit,
  input  logic                         rx_valid,
  input  logic                         rx_sof,
  output logic [WIDTH-1:0][DEPTH-1:0]  data_out,
  output logic [DEPTH-1:0]             row_parity_out,
  output logic [WIDTH-1:0]             col_parity_out,
  output logic                         dec_start,
  input  logic                         dec_done,
  output logic                         busy,
  output logic                         frame_err,
  output logic [7:0]                   frame_cnt
);

  localparam int WD = WIDTH * DEPTH;
  localparam int N  = WD + DEPTH + WIDTH;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    ISSUE,
    WAIT
  } state_t;

  state_t                     state_q;
  logic [CW-1:0]              cnt_q;
  logic [N-1:0]               shadow_q;
  logic [N-1:0]               full_d;
  logic [WIDTH-1:0][DEPTH-1:0] data_q;
  logic [DEPTH-1:0]           row_q;
  logic [WIDTH-1:0]           col_q;
  logic                       start_q;
  logic                       err_q;
  logic [7:0]                 cnt8_q;
  logic                       sof_v;
  logic                       bit_v;

  assign sof_v = rx_valid & rx_sof;
  assign bit_v = rx_valid & ~rx_sof;

  // Complete frame as it will look once the final bit lands.
  always_comb begin
    full_d         = shadow_q;
    full_d[N-1]    = rx_bit;
  end

  // Frame FSM with registered handoff outputs and error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt8_q   <= '0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sof_v) begin
            shadow_q[0] <= rx_bit;
            cnt_q       <= CW'(1);
            state_q     <= COLLECT;
          end
        end
        COLLECT: begin
          if (sof_v) begin
            err_q       <= 1'b1;
            shadow_q[0] <= rx_bit;
            cnt_q       <= CW'(1);
          end else if (bit_v) begin
            shadow_q[cnt_q] <= rx_bit;
            if (cnt_q == LAST) begin
              data_q  <= full_d[WD-1:0];
              row_q   <= full_d[WD +: DEPTH];
              col_q   <= full_d[WD+DEPTH +: WIDTH];
              start_q <= 1'b1;
              cnt8_q  <= cnt8_q + 8'd1;
              cnt_q   <= '0;
              state_q <= ISSUE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ISSUE: begin
          if (sof_v) err_q <= 1'b1;
          state_q <= dec_done ? IDLE : WAIT;
        end
        WAIT: begin
          if (sof_v) err_q <= 1'b1;
          if (dec_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out       = data_q;
  assign row_parity_out = row_q;
  assign col_parity_out = col_q;
  assign dec_start      = start_q;
  assign frame_err      = err_q;
  assign frame_cnt      = cnt8_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_fec_rx_deframer.sv
// tb_fec_rx_deframer: scoreboard bench for fec_rx_deframer.
// Expected frames queued at drive time, popped on dec_start.
module tb_fec_rx_deframer;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_bit;
  logic        rx_valid;
  logic        rx_sof;
  logic [3:0][3:0] data_out;
  logic [3:0]  row_parity_out;
  logic [3:0]  col_parity_out;
  logic        dec_start;
  logic        dec_done;
  logic        busy;
  logic        frame_err;
  logic [7:0]  frame_cnt;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          n_start = 0;
  int          n_err = 0;
  int          exp_err = 0;
  logic [7:0]  exp_cnt = 8'd0;

  fec_rx_deframer #(.WIDTH(4), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_bit         (rx_bit),
    .rx_valid       (rx_valid),
    .rx_sof         (rx_sof),
    .data_out       (data_out),
    .row_parity_out (row_parity_out),
    .col_parity_out (col_parity_out),
    .dec_start      (dec_start),
    .dec_done       (dec_done),
    .busy           (busy),
    .frame_err      (frame_err),
    .frame_cnt      (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: compare each handoff against the queue.
  always @(negedge clk) begin
    if (frame_err) n_err++;
    if (dec_start) begin
      n_start++;
      if (sb_q.size() == 0) begin
        chk("unexpected_start", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("data", 32'(data_out), 32'(e.data));
        chk("row", 32'(row_parity_out), 32'(e.row));
        chk("col", 32'(col_parity_out), 32'(e.col));
        chk("cnt", 32'(frame_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic send_partial(input logic [23:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_sof   = (i == 0);
      rx_bit   = bits[i];
      tick();
    end
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] d, input logic [3:0] r,
                            input logic [3:0] c, input bit gap);
    logic [23:0] bits;
    exp_t e;
    bits = {c, r, d};
    for (int i = 0; i < 24; i++) begin
      if (i == 23) begin
        exp_cnt = exp_cnt + 8'd1;
        e.data = d; e.row = r; e.col = c; e.cnt = exp_cnt;
        sb_q.push_back(e);
      end
      rx_valid = 1'b1;
      rx_sof   = (i == 0);
      rx_bit   = bits[i];
      tick();
      if (gap && i != 23) begin
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        tick();
      end
    end
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
    chk("start_latency", 32'(dec_start), 32'd1);
    tick();
    chk("start_one_cycle", 32'(dec_start), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_sof = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_cnt = 8'd0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    rx_bit = 1'b0;
    dec_done = 1'b1;
    do_reset();
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_row", 32'(row_parity_out), 32'd0);
    chk("rst_col", 32'(col_parity_out), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(dec_start), 32'd0);

    // Contiguous frame, then stalled frame.
    send_frame(16'hA5C3, 4'h6, 4'h9, 1'b0);
    send_frame(16'hA5C3, 4'h6, 4'h9, 1'b1);

    // sof reasserted mid-frame.
    send_partial(24'h5A5A5A, 10);
    exp_err++;
    send_frame(16'h1234, 4'h3, 4'hC, 1'b0);
    chk("err_midframe", 32'(n_err), 32'(exp_err));

    // Overrun during WAIT.
    dec_done = 1'b0;
    send_frame(16'hBEEF, 4'hA, 4'h5, 1'b0);
    chk("busy_wait", 32'(busy), 32'd1);
    send_partial(24'hFFFFFF, 24);
    exp_err++;
    tick();
    chk("err_overrun", 32'(n_err), 32'(exp_err));
    chk("hold_data", 32'(data_out), 32'hBEEF);
    chk("hold_col", 32'(col_parity_out), 32'h5);
    chk("busy_still", 32'(busy), 32'd1);
    dec_done = 1'b1;
    tick();
    chk("busy_done", 32'(busy), 32'd0);
    send_frame(16'h0F0F, 4'h1, 4'h8, 1'b0);

    // Reset in the middle of a frame.
    send_partial(24'h123456, 12);
    s0 = n_start;
    do_reset();
    tick();
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
    chk("mid_rst_nostart", 32'(n_start), 32'(s0));
    send_frame(16'h7E81, 4'hF, 4'h0, 1'b0);

    // 256 back-to-back frames, counter wrap.
    do_reset();
    s0 = n_start;
    for (int k = 0; k < 256; k++) begin
      send_frame(16'($urandom), 4'($urandom), 4'($urandom), 1'b0);
    end
    tick();
    chk("wrap_starts", 32'(n_start - s0), 32'd256);
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("err_total", 32'(n_err), 32'(exp_err));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
